// File: rtl/store_buffer.sv
// Committed-store buffer feeding the dual-port data cache: two enqueues, two
// drains (oldest on port 1) and youngest-match load forwarding per cycle.
module store_buffer #(
   parameter int DEPTH    = 8,
   parameter int dataSize = 32,
   parameter int addrSize = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        st1_valid,
   input  logic                        st2_valid,
   input  logic [addrSize-1:0]         st1_addr,
   input  logic [addrSize-1:0]         st2_addr,
   input  logic [dataSize-1:0]         st1_data,
   input  logic [dataSize-1:0]         st2_data,
   output logic                        st_ready,
   input  logic                        drain_en,
   output logic                        mem_we1,
   output logic                        mem_we2,
   output logic [addrSize-1:0]         mem_addr1,
   output logic [addrSize-1:0]         mem_addr2,
   output logic [dataSize-1:0]         mem_wdata1,
   output logic [dataSize-1:0]         mem_wdata2,
   input  logic [addrSize-1:0]         ld1_addr,
   input  logic [addrSize-1:0]         ld2_addr,
   output logic                        ld1_hit,
   output logic                        ld2_hit,
   output logic [dataSize-1:0]         ld1_data,
   output logic [dataSize-1:0]         ld2_data,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   typedef logic [PW-1:0] ptr_t;

   logic [addrSize-1:0] addr_q [DEPTH];
   logic [dataSize-1:0] data_q [DEPTH];
   ptr_t                head, tail, head1, tail2;
   logic [CW-1:0]       count_q;
   logic                enq1, enq2;
   logic [1:0]          enq_n, drain_n;

   assign count    = count_q;
   assign empty    = (count_q == '0);
   // Ready looks only at registered occupancy; same-cycle drains never add room.
   assign st_ready = (count_q <= CW'(DEPTH - 2));
   assign enq1     = st_ready & st1_valid;
   assign enq2     = st_ready & st2_valid;
   assign enq_n    = {1'b0, enq1} + {1'b0, enq2};
   assign tail2    = enq1 ? tail + ptr_t'(1) : tail;

   assign head1      = head + ptr_t'(1);
   assign mem_we1    = drain_en & (count_q >= CW'(1));
   assign mem_we2    = drain_en & (count_q >= CW'(2));
   assign drain_n    = {1'b0, mem_we1} + {1'b0, mem_we2};
   assign mem_addr1  = addr_q[head];
   assign mem_wdata1 = data_q[head];
   assign mem_addr2  = addr_q[head1];
   assign mem_wdata2 = data_q[head1];

   logic [1:0][addrSize-1:0] ld_addr;
   logic [1:0]               ld_hit;
   logic [1:0][dataSize-1:0] ld_data;

   assign ld_addr  = {ld2_addr, ld1_addr};
   assign ld1_hit  = ld_hit[0];
   assign ld2_hit  = ld_hit[1];
   assign ld1_data = ld_data[0];
   assign ld2_data = ld_data[1];

   // Walk occupied entries oldest to youngest so the last match is the youngest,
   // independent of where the ring has wrapped.
   always_comb begin
      ptr_t idx;
      idx     = '0;
      ld_hit  = '0;
      ld_data = '0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < DEPTH; i++) begin
            idx = head + ptr_t'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == ld_addr[p])) begin
               ld_hit[p]  = 1'b1;
               ld_data[p] = data_q[idx];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (enq1) begin
            addr_q[tail] <= st1_addr;
            data_q[tail] <= st1_data;
         end
         if (enq2) begin
            addr_q[tail2] <= st2_addr;
            data_q[tail2] <= st2_data;
         end
         tail    <= tail + ptr_t'(enq_n);
         head    <= head + ptr_t'(drain_n);
         count_q <= count_q + CW'(enq_n) - CW'(drain_n);
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, drain, forwarding, ready boundary,
// ring wrap and simultaneous enqueue/drain.
module tb_store_buffer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        st1_valid, st2_valid;
   logic [31:0] st1_addr, st2_addr, st1_data, st2_data;
   logic        st_ready, drain_en;
   logic        mem_we1, mem_we2;
   logic [31:0] mem_addr1, mem_addr2, mem_wdata1, mem_wdata2;
   logic [31:0] ld1_addr, ld2_addr, ld1_data, ld2_data;
   logic        ld1_hit, ld2_hit;
   logic [3:0]  count;
   logic        empty;
   int          ncmp = 0;
   int          nerr = 0;

   store_buffer #(.DEPTH(8), .dataSize(32), .addrSize(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .st1_valid(st1_valid), .st2_valid(st2_valid),
      .st1_addr(st1_addr), .st2_addr(st2_addr),
      .st1_data(st1_data), .st2_data(st2_data),
      .st_ready(st_ready), .drain_en(drain_en),
      .mem_we1(mem_we1), .mem_we2(mem_we2),
      .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
      .mem_wdata1(mem_wdata1), .mem_wdata2(mem_wdata2),
      .ld1_addr(ld1_addr), .ld2_addr(ld2_addr),
      .ld1_hit(ld1_hit), .ld2_hit(ld2_hit),
      .ld1_data(ld1_data), .ld2_data(ld2_data),
      .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic v1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic v2, input logic [31:0] a2, input logic [31:0] d2);
      st1_valid = v1; st1_addr = a1; st1_data = d1;
      st2_valid = v2; st2_addr = a2; st2_data = d2;
      cyc();
      st1_valid = 1'b0; st2_valid = 1'b0;
   endtask

   task automatic test_reset();
      ncmp++; if (count !== 4'd0 || empty !== 1'b1 || st_ready !== 1'b1) begin nerr++;
         $display("FAIL reset_state count=%0d empty=%0b ready=%0b want 0/1/1", count, empty, st_ready); end
      ncmp++; if (ld1_hit !== 1'b0 || ld1_data !== 32'h0 || mem_addr1 !== 32'h0 || mem_wdata2 !== 32'h0) begin nerr++;
         $display("FAIL reset_outputs hit=%0b ldata=%h maddr=%h mwd2=%h want zeros", ld1_hit, ld1_data, mem_addr1, mem_wdata2); end
      drain_en = 1'b1; #1;
      ncmp++; if (mem_we1 !== 1'b0 || mem_we2 !== 1'b0) begin nerr++;
         $display("FAIL reset_we_empty we1=%0b we2=%0b want 0/0", mem_we1, mem_we2); end
      drain_en = 1'b0;
      push(1, 32'h100, 32'h1, 1, 32'h104, 32'h2);
      push(1, 32'h108, 32'h3, 1, 32'h10C, 32'h4);
      push(1, 32'h110, 32'h5, 0, 32'h0, 32'h0);
      ncmp++; if (count !== 4'd5) begin nerr++;
         $display("FAIL pre_reset_count got %0d want 5", count); end
      drain_en = 1'b1; #1;
      ncmp++; if (mem_we1 !== 1'b1 || mem_we2 !== 1'b1) begin nerr++;
         $display("FAIL pre_reset_we we1=%0b we2=%0b want 1/1", mem_we1, mem_we2); end
      rst_n = 1'b0; #1;
      ncmp++; if (count !== 4'd0 || empty !== 1'b1 || st_ready !== 1'b1 || mem_we1 !== 1'b0 || mem_we2 !== 1'b0) begin nerr++;
         $display("FAIL async_reset count=%0d empty=%0b ready=%0b we=%0b%0b want 0/1/1/00",
                  count, empty, st_ready, mem_we1, mem_we2); end
      drain_en = 1'b0; rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_dual_drain();
      push(1, 32'h13, 32'hAAAA0001, 1, 32'h23, 32'hBBBB0002);
      ncmp++; if (count !== 4'd2 || mem_we1 !== 1'b0) begin nerr++;
         $display("FAIL dd_enq count=%0d we1=%0b want 2/0", count, mem_we1); end
      drain_en = 1'b1; #1;
      ncmp++; if (mem_we1 !== 1'b1 || mem_we2 !== 1'b1 || mem_addr1 !== 32'h13 || mem_addr2 !== 32'h23) begin nerr++;
         $display("FAIL dd_addr we=%0b%0b a1=%h a2=%h want 11/13/23", mem_we1, mem_we2, mem_addr1, mem_addr2); end
      ncmp++; if (mem_wdata1 !== 32'hAAAA0001 || mem_wdata2 !== 32'hBBBB0002) begin nerr++;
         $display("FAIL dd_data d1=%h d2=%h want AAAA0001/BBBB0002", mem_wdata1, mem_wdata2); end
      cyc(); drain_en = 1'b0; #1;
      ncmp++; if (count !== 4'd0 || empty !== 1'b1) begin nerr++;
         $display("FAIL dd_after count=%0d empty=%0b want 0/1", count, empty); end
   endtask

   task automatic test_forward();
      ld1_addr = 32'h43; ld2_addr = 32'h63;
      st1_valid = 1'b1; st1_addr = 32'h43; st1_data = 32'h11111111; #1;
      ncmp++; if (ld1_hit !== 1'b0) begin nerr++;
         $display("FAIL fwd_same_cycle hit=%0b want 0", ld1_hit); end
      push(1, 32'h43, 32'h11111111, 0, 32'h0, 32'h0);
      push(1, 32'h43, 32'h22222222, 0, 32'h0, 32'h0);
      push(1, 32'h53, 32'h33333333, 0, 32'h0, 32'h0);
      ncmp++; if (ld1_hit !== 1'b1 || ld1_data !== 32'h22222222) begin nerr++;
         $display("FAIL fwd_youngest hit=%0b data=%h want 1/22222222", ld1_hit, ld1_data); end
      ncmp++; if (ld2_hit !== 1'b0 || ld2_data !== 32'h0) begin nerr++;
         $display("FAIL fwd_miss hit=%0b data=%h want 0/0", ld2_hit, ld2_data); end
      drain_en = 1'b1; #1;
      ncmp++; if (ld1_hit !== 1'b1 || ld1_data !== 32'h22222222) begin nerr++;
         $display("FAIL fwd_draining hit=%0b data=%h want 1/22222222", ld1_hit, ld1_data); end
      cyc();
      ncmp++; if (ld1_hit !== 1'b0 || count !== 4'd1) begin nerr++;
         $display("FAIL fwd_drained hit=%0b count=%0d want 0/1", ld1_hit, count); end
      cyc(); drain_en = 1'b0;
      ld1_addr = 32'h0; ld2_addr = 32'h0;
   endtask

   task automatic test_full();
      for (int i = 0; i < 3; i++)
         push(1, 32'h200 + 32'(i), 32'h0, 1, 32'h300 + 32'(i), 32'h0);
      ncmp++; if (count !== 4'd6 || st_ready !== 1'b1) begin nerr++;
         $display("FAIL full_six count=%0d ready=%0b want 6/1", count, st_ready); end
      push(1, 32'h400, 32'h0, 0, 32'h0, 32'h0);
      ncmp++; if (count !== 4'd7 || st_ready !== 1'b0) begin nerr++;
         $display("FAIL full_seven count=%0d ready=%0b want 7/0", count, st_ready); end
      drain_en = 1'b1;
      cyc();
      ncmp++; if (count !== 4'd5 || st_ready !== 1'b1) begin nerr++;
         $display("FAIL full_drain count=%0d ready=%0b want 5/1", count, st_ready); end
      for (int i = 0; i < 3; i++) cyc();
      drain_en = 1'b0;
      ncmp++; if (count !== 4'd0) begin nerr++;
         $display("FAIL full_empty count=%0d want 0", count); end
   endtask

   task automatic test_wrap();
      // head is at 4: three throwaway entries bring head to 7
      push(1, 32'hE0, 32'h0, 1, 32'hE1, 32'h0);
      push(1, 32'hE2, 32'h0, 0, 32'h0, 32'h0);
      drain_en = 1'b1; cyc(); cyc(); drain_en = 1'b0;
      push(1, 32'h70, 32'h70707070, 1, 32'h80, 32'h80808080);
      push(1, 32'h70, 32'h71717171, 1, 32'h90, 32'h90909090);
      ld1_addr = 32'h70; ld2_addr = 32'h80; #1;
      ncmp++; if (count !== 4'd4 || ld1_hit !== 1'b1 || ld1_data !== 32'h71717171) begin nerr++;
         $display("FAIL wrap_fwd count=%0d hit=%0b data=%h want 4/1/71717171", count, ld1_hit, ld1_data); end
      ncmp++; if (ld2_hit !== 1'b1 || ld2_data !== 32'h80808080) begin nerr++;
         $display("FAIL wrap_fwd2 hit=%0b data=%h want 1/80808080", ld2_hit, ld2_data); end
      drain_en = 1'b1; #1;
      ncmp++; if (mem_addr1 !== 32'h70 || mem_wdata1 !== 32'h70707070 || mem_addr2 !== 32'h80 || mem_wdata2 !== 32'h80808080) begin nerr++;
         $display("FAIL wrap_drain a1=%h d1=%h a2=%h d2=%h want 70/70707070/80/80808080",
                  mem_addr1, mem_wdata1, mem_addr2, mem_wdata2); end
      cyc();
      ncmp++; if (count !== 4'd2 || mem_addr1 !== 32'h70 || mem_wdata1 !== 32'h71717171 || mem_addr2 !== 32'h90) begin nerr++;
         $display("FAIL wrap_drain2 count=%0d a1=%h d1=%h a2=%h want 2/70/71717171/90",
                  count, mem_addr1, mem_wdata1, mem_addr2); end
      cyc(); drain_en = 1'b0;
      ld1_addr = 32'h0; ld2_addr = 32'h0;
   endtask

   task automatic test_back_to_back();
      push(1, 32'hA0, 32'h1, 1, 32'hA1, 32'h2);
      push(1, 32'hA2, 32'h3, 0, 32'h0, 32'h0);
      drain_en = 1'b1; #1;
      ncmp++; if (count !== 4'd3 || mem_addr1 !== 32'hA0 || mem_addr2 !== 32'hA1) begin nerr++;
         $display("FAIL b2b_pre count=%0d a1=%h a2=%h want 3/A0/A1", count, mem_addr1, mem_addr2); end
      push(1, 32'hB0, 32'h4, 1, 32'hB1, 32'h5);
      drain_en = 1'b0; #1;
      ncmp++; if (count !== 4'd3 || mem_addr1 !== 32'hA2 || mem_addr2 !== 32'hB0) begin nerr++;
         $display("FAIL b2b_post count=%0d a1=%h a2=%h want 3/A2/B0", count, mem_addr1, mem_addr2); end
      // lone st2 lands in the tail slot, which has wrapped to index 0
      push(0, 32'h0, 32'h0, 1, 32'hD0, 32'h6);
      drain_en = 1'b1; cyc(); #1;
      ncmp++; if (count !== 4'd2 || mem_addr1 !== 32'hB1 || mem_addr2 !== 32'hD0 || mem_wdata2 !== 32'h6) begin nerr++;
         $display("FAIL b2b_lone_st2 count=%0d a1=%h a2=%h d2=%h want 2/B1/D0/6",
                  count, mem_addr1, mem_addr2, mem_wdata2); end
      cyc(); drain_en = 1'b0;
      ncmp++; if (count !== 4'd0 || empty !== 1'b1) begin nerr++;
         $display("FAIL b2b_empty count=%0d empty=%0b want 0/1", count, empty); end
   endtask

   initial begin
      rst_n = 1'b0; drain_en = 1'b0;
      st1_valid = 1'b0; st2_valid = 1'b0;
      st1_addr = '0; st2_addr = '0; st1_data = '0; st2_data = '0;
      ld1_addr = '0; ld2_addr = '0;
      #12 rst_n = 1'b1;
      test_reset();
      test_dual_drain();
      test_forward();
      test_full();
      test_wrap();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
